// File: rtl/mem_pkg.sv
// Shared load/store definitions for the data memory path.
// RV32 width/sign codes plus lane and alignment helpers.
package mem_pkg;

    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } ls_funct3_e;

    function automatic logic ls_bad(
        input logic [2:0] f,
        input logic [1:0] lo
    );
        logic bad;
        bad = 1'b1;
        unique case (1'b1)
            f == LS_B,
            f == LS_BU: bad = 1'b0;
            f == LS_H,
            f == LS_HU: bad = lo[0];
            f == LS_W:  bad = |lo;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] ls_lanes(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic [3:0] m;
        m = 4'b1111;
        unique case (1'b1)
            size == 2'd0: m = 4'b0001 << lo;
            size == 2'd1: m = 4'b0011 << lo;
            default:      m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/byte_bank.sv
// One byte lane of the data RAM: synchronous write and
// registered read that holds while the pipeline is stalled.
module byte_bank #(
    parameter int ENTRIES = 1024
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic                       re,
    input  logic [$clog2(ENTRIES)-1:0] addr,
    input  logic [7:0]                 wdata,
    output logic [7:0]                 rdata
);

    logic [7:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_ram_banked.sv
// Byte-banked data RAM with RV32 load/store semantics,
// valid/ready request and response, 1 or 2 cycle latency.
module data_ram_banked
    import mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 4096,
    parameter int RD_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int IW = AW - 2;

    logic          stall;
    logic          acc;
    logic          rq_err;
    logic          wr_ok;
    logic [3:0]    lanes;
    logic [31:0]   wrep;
    logic [IW-1:0] idx;
    logic [7:0]    rd [4];

    logic        s1_v;
    logic        s1_we;
    logic        s1_err;
    logic [2:0]  s1_f;
    logic [1:0]  s1_lo;
    logic [31:0] word;
    logic [31:0] sh;
    logic [31:0] ext;
    logic [31:0] s1_data;

    logic        o_v;
    logic        o_e;
    logic [31:0] o_d;

    assign stall     = rsp_valid && !rsp_ready;
    assign req_ready = !stall;
    assign acc       = req_valid && req_ready;
    assign idx       = req_addr[AW-1:2];

    assign rq_err = ls_bad(req_funct3, req_addr[1:0])
                 || (|req_addr[31:AW]);
    assign lanes  = ls_lanes(req_funct3[1:0], req_addr[1:0]);
    assign wr_ok  = acc && req_we && !rq_err && rst_n;

    // Replicate store data so every lane sees its own byte.
    always_comb begin
        wrep = req_wdata;
        unique case (1'b1)
            req_funct3[1:0] == 2'd0:
                wrep = {4{req_wdata[7:0]}};
            req_funct3[1:0] == 2'd1:
                wrep = {2{req_wdata[15:0]}};
            default:
                wrep = req_wdata;
        endcase
    end

    for (genvar l = 0; l < 4; l++) begin : g_bank
        byte_bank #(
            .ENTRIES(DEPTH_BYTES / 4)
        ) u_bank (
            .clk  (clk),
            .we   (wr_ok && lanes[l]),
            .re   (!stall),
            .addr (idx),
            .wdata(wrep[8*l +: 8]),
            .rdata(rd[l])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_we  <= 1'b0;
            s1_err <= 1'b0;
            s1_f   <= 3'd0;
            s1_lo  <= 2'd0;
        end else if (!stall) begin
            s1_v   <= acc;
            s1_we  <= req_we;
            s1_err <= rq_err;
            s1_f   <= req_funct3;
            s1_lo  <= req_addr[1:0];
        end
    end

    assign word = {rd[3], rd[2], rd[1], rd[0]};
    assign sh   = word >> {s1_lo, 3'b000};

    always_comb begin
        ext = word;
        unique case (1'b1)
            s1_f == LS_B:  ext = {{24{sh[7]}}, sh[7:0]};
            s1_f == LS_BU: ext = {24'd0, sh[7:0]};
            s1_f == LS_H:  ext = {{16{sh[15]}}, sh[15:0]};
            s1_f == LS_HU: ext = {16'd0, sh[15:0]};
            default:       ext = word;
        endcase
    end

    assign s1_data = (s1_err || s1_we) ? 32'd0 : ext;

    if (RD_LAT == 2) begin : g_lat2
        logic        s2_v;
        logic        s2_e;
        logic [31:0] s2_d;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s2_v <= 1'b0;
                s2_e <= 1'b0;
                s2_d <= 32'd0;
            end else if (!stall) begin
                s2_v <= s1_v;
                s2_e <= s1_err;
                s2_d <= s1_data;
            end
        end

        assign o_v = s2_v;
        assign o_e = s2_e;
        assign o_d = s2_d;
    end else begin : g_lat1
        assign o_v = s1_v;
        assign o_e = s1_err;
        assign o_d = s1_data;
    end

    assign rsp_valid = o_v;
    assign rsp_rdata = o_v ? o_d : 32'd0;
    assign rsp_err   = o_v && o_e;

endmodule

// File: tb/tb_data_ram_banked.sv
// Randomized and directed bench for data_ram_banked over
// RD_LAT 1/2 and DEPTH_BYTES 4096/256, byte-array model.
module tb_data_ram_banked;

    int tests = 0;
    int fails = 0;
    bit done [4];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", nm);
    endtask

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int LAT = (g % 2) + 1;
        localparam int DEP = (g < 2) ? 4096 : 256;

        typedef struct {
            logic [31:0] d;
            logic        e;
        } exp_t;

        logic        rst_n;
        logic        req_valid;
        logic        req_ready;
        logic        req_we;
        logic [2:0]  req_f;
        logic [31:0] req_addr;
        logic [31:0] req_wdata;
        logic        rsp_valid;
        logic        rsp_ready;
        logic [31:0] rsp_rdata;
        logic        rsp_err;

        logic [7:0]  mem [DEP];
        exp_t        q [$];
        logic [31:0] got [$];
        logic [2:0]  legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        data_ram_banked #(
            .DEPTH_BYTES(DEP),
            .RD_LAT     (LAT)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid),
            .req_ready (req_ready),
            .req_we    (req_we),
            .req_funct3(req_f),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .rsp_valid (rsp_valid),
            .rsp_ready (rsp_ready),
            .rsp_rdata (rsp_rdata),
            .rsp_err   (rsp_err)
        );

        task automatic ck(
            input string       nm,
            input logic [31:0] act,
            input logic [31:0] exp
        );
            check($sformatf("L%0dD%0d_%s", LAT, DEP, nm), act, exp);
        endtask

        function automatic exp_t mref(
            input logic        we_i,
            input logic [2:0]  f_i,
            input logic [31:0] a_i,
            input logic [31:0] d_i
        );
            exp_t        r;
            int          n;
            bit          bad;
            logic [31:0] v;
            n = (f_i[1:0] == 2'd0) ? 1 : (f_i[1:0] == 2'd1) ? 2 : 4;
            bad = (f_i == 3'd3) || (f_i == 3'd6) || (f_i == 3'd7);
            bad = bad || ((a_i % n) != 0) || (a_i >= 32'(DEP));
            r.d = 32'd0;
            r.e = bad;
            if (bad || we_i) begin
                if (!bad)
                    for (int i = 0; i < n; i++)
                        mem[a_i + i] = d_i[8*i +: 8];
                return r;
            end
            v = 32'd0;
            for (int i = 0; i < n; i++)
                v[8*i +: 8] = mem[a_i + i];
            if (!f_i[2] && n < 4 && v[8*n-1])
                for (int j = 8 * n; j < 32; j++)
                    v[j] = 1'b1;
            r.d = v;
            return r;
        endfunction

        // Every cycle: handshake rule, response vs model queue.
        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
            end else begin
                ck("rdy_rule", req_ready,
                   !(rsp_valid && !rsp_ready));
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        ck("unexpected_rsp", rsp_valid, 0);
                    end else begin
                        ck("rsp_data", rsp_rdata, q[0].d);
                        ck("rsp_err", rsp_err, q[0].e);
                    end
                    if (rsp_ready) begin
                        got.push_back(rsp_rdata);
                        if (q.size() != 0) void'(q.pop_front());
                    end
                end
                if (req_valid && req_ready)
                    q.push_back(mref(req_we, req_f,
                                     req_addr, req_wdata));
            end
        end

        task automatic issue(
            input logic        we_i,
            input logic [2:0]  f_i,
            input logic [31:0] a_i,
            input logic [31:0] d_i,
            input string       nm
        );
            bit ok;
            ok = 0;
            req_valid = 1;
            req_we    = we_i;
            req_f     = f_i;
            req_addr  = a_i;
            req_wdata = d_i;
            for (int k = 0; k < 20 && !ok; k++) begin
                @(negedge clk);
                ok = req_ready;
                @(posedge clk);
                #1;
            end
            req_valid = 0;
            if (!ok) fail_now($sformatf("L%0dD%0d_%s_acc", LAT, DEP, nm));
        endtask

        task automatic dcheck(
            input logic        we_i,
            input logic [2:0]  f_i,
            input logic [31:0] a_i,
            input logic [31:0] d_i,
            input logic [31:0] exp_d,
            input logic        exp_e,
            input string       nm
        );
            issue(we_i, f_i, a_i, d_i, nm);
            for (int k = 0; k < LAT - 1; k++) begin
                @(negedge clk);
                ck({nm, "_early"}, rsp_valid, 0);
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            ck({nm, "_vld"}, rsp_valid, 1);
            ck({nm, "_data"}, rsp_rdata, exp_d);
            ck({nm, "_err"}, rsp_err, exp_e);
            @(posedge clk);
            #1;
        endtask

        task automatic drain(input string nm);
            bit ok;
            ok = 0;
            req_valid = 0;
            rsp_ready = 1;
            for (int k = 0; k < 60 && !ok; k++) begin
                @(negedge clk);
                ok = (q.size() == 0) && !rsp_valid;
                @(posedge clk);
                #1;
            end
            if (!ok) fail_now($sformatf("L%0dD%0d_%s", LAT, DEP, nm));
        endtask

        initial begin
            int  idx;
            bit  saw;
            int  n;
            rst_n     = 0;
            req_valid = 0;
            req_we    = 0;
            req_f     = 3'd0;
            req_addr  = 32'd0;
            req_wdata = 32'd0;
            rsp_ready = 1;
            repeat (2) @(posedge clk);
            @(negedge clk);
            ck("rst_vld", rsp_valid, 0);
            ck("rst_data", rsp_rdata, 0);
            ck("rst_err", rsp_err, 0);
            ck("rst_rdy", req_ready, 1);
            @(posedge clk);
            #1;
            rst_n = 1;

            // Fill every word so the model knows all contents.
            for (int w = 0; w < DEP / 4; w++) begin
                req_valid = 1;
                req_we    = 1;
                req_f     = 3'd2;
                req_addr  = 32'(w * 4);
                req_wdata = $urandom;
                @(posedge clk);
                #1;
            end
            drain("init_drain");

            dcheck(1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0, "sw10");
            dcheck(0, 3'd2, 32'h10, 0, 32'hDEADBEEF, 0, "lw10");
            dcheck(1, 3'd0, 32'h13, 32'h80, 0, 0, "sb13");
            dcheck(0, 3'd0, 32'h13, 0, 32'hFFFFFF80, 0, "lb13");
            dcheck(0, 3'd4, 32'h13, 0, 32'h00000080, 0, "lbu13");
            dcheck(0, 3'd2, 32'h10, 0, 32'h80ADBEEF, 0, "lw10b");
            dcheck(1, 3'd2, 32'h20, 32'h12345678, 0, 0, "sw20");
            dcheck(0, 3'd1, 32'h11, 0, 0, 1, "lh11_mis");
            dcheck(1, 3'd2, 32'h22, 32'hCAFEF00D, 0, 1, "sw22_mis");
            dcheck(0, 3'd2, 32'(DEP), 0, 0, 1, "lw_oor");
            dcheck(1, 3'd3, 32'h20, 32'hFFFFFFFF, 0, 1, "st_f3");
            dcheck(0, 3'd7, 32'h20, 0, 0, 1, "ld_f7");
            dcheck(0, 3'd2, 32'h20, 0, 32'h12345678, 0, "lw20");
            dcheck(1, 3'd1, 32'h1A, 32'h55558001, 0, 0, "sh1a");
            dcheck(0, 3'd1, 32'h1A, 0, 32'hFFFF8001, 0, "lh1a");
            dcheck(0, 3'd5, 32'h1A, 0, 32'h00008001, 0, "lhu1a");
            dcheck(0, 3'd2, 32'h18, 0, {16'h8001, mem[25], mem[24]},
                   0, "lw18");

            dcheck(1, 3'd2, 32'h0, 32'h11111111, 0, 0, "sw0");
            dcheck(1, 3'd2, 32'h4, 32'h22222222, 0, 0, "sw4");
            dcheck(1, 3'd2, 32'h8, 32'h33333333, 0, 0, "sw8");

            // Back-to-back loads with a 3-cycle consumer stall.
            got.delete();
            idx = 0;
            saw = 0;
            for (int c = 0; c < 40; c++) begin
                req_valid = (idx < 3);
                req_we    = 0;
                req_f     = 3'd2;
                req_addr  = 32'(idx * 4);
                rsp_ready = !(c >= LAT && c < LAT + 3);
                @(negedge clk);
                if (rsp_valid && !rsp_ready) begin
                    saw = 1;
                    ck("stall_rdy", req_ready, 0);
                end
                if (req_valid && req_ready) idx++;
                @(posedge clk);
                #1;
                if (idx == 3 && got.size() >= 3 && c > LAT + 6) break;
            end
            req_valid = 0;
            rsp_ready = 1;
            repeat (3) @(posedge clk);
            #1;
            ck("stall_seen", saw, 1);
            ck("stream_cnt", got.size(), 3);
            if (got.size() == 3) begin
                ck("stream0", got[0], 32'h11111111);
                ck("stream1", got[1], 32'h22222222);
                ck("stream2", got[2], 32'h33333333);
            end

            // Reset with loads in flight.
            rsp_ready = 0;
            req_valid = 1;
            req_we    = 0;
            req_f     = 3'd2;
            req_addr  = 32'h10;
            @(posedge clk);
            #1;
            req_addr = 32'h4;
            @(posedge clk);
            #1;
            req_valid = 0;
            rst_n     = 0;
            @(posedge clk);
            @(negedge clk);
            ck("mrst_vld", rsp_valid, 0);
            ck("mrst_rdy", req_ready, 1);
            ck("mrst_err", rsp_err, 0);
            @(posedge clk);
            #1;
            rst_n     = 1;
            rsp_ready = 1;
            repeat (4) @(posedge clk);
            #1;
            dcheck(0, 3'd2, 32'h10, 0, 32'h80ADBEEF, 0, "ret10");
            dcheck(0, 3'd2, 32'h4, 0, 32'h22222222, 0, "ret4");

            // Random traffic against the byte model.
            for (int c = 0; c < 600; c++) begin
                int r;
                req_valid = ($urandom % 5) != 0;
                req_we    = $urandom % 2;
                r = $urandom % 10;
                req_f = (r < 8) ? legal[$urandom % 5]
                                : 3'($urandom % 8);
                r = $urandom % 20;
                if (r == 0)
                    req_addr = 32'(DEP) + ($urandom % 16);
                else if (r == 1)
                    req_addr = $urandom;
                else
                    req_addr = $urandom % DEP;
                n = (req_f[1:0] == 2'd0) ? 1
                  : (req_f[1:0] == 2'd1) ? 2 : 4;
                if (($urandom % 5) != 0)
                    req_addr = req_addr & ~(32'(n) - 1);
                req_wdata = $urandom;
                rsp_ready = ($urandom % 4) != 0;
                @(posedge clk);
                #1;
            end
            drain("rand_drain");
            done[g] = 1;
        end
    end

    initial begin
        bit all;
        all = 0;
        for (int c = 0; c < 20000 && !all; c++) begin
            @(posedge clk);
            all = done[0] && done[1] && done[2] && done[3];
        end
        if (!all) fail_now("global_timeout");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_ram_banked.md
DATA_RAM_BANKED -- requirements
Module: data_ram_banked

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 4096, meaning byte capacity; power of two, at least 16.
REQ-002 SHALL have parameter RD_LAT, default 1, meaning request-to-response latency in cycles; legal values 1 or 2.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset; synchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1, meaning a request is present.
REQ-006 SHALL have port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1, meaning store (1) or load (0).
REQ-008 SHALL have port req_funct3, input, 3, meaning RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port req_addr, input, 32, meaning byte address.
REQ-010 SHALL have port req_wdata, input, 32, meaning store data, LSB-aligned.
REQ-011 SHALL have port rsp_valid, output, 1, meaning a response is present.
REQ-012 SHALL have port rsp_ready, input, 1, meaning the consumer takes the response.
REQ-013 SHALL have port rsp_rdata, output, 32, meaning extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1, meaning misaligned, out-of-range or illegal-funct3 request.

Function
REQ-015 SHALL accept a request on a rising edge where req_valid && req_ready.
REQ-016 SHALL hold storage as 4 byte-lane banks of DEPTH_BYTES/4 entries: word index is req_addr[log2(DEPTH_BYTES)-1:2], lane is req_addr[1:0].
REQ-017 SHALL flag an error when: H/HU with addr[0]=1; W with addr[1:0]!=0; addr >= DEPTH_BYTES; or funct3 is 011, 110 or 111 (for both loads and stores).
REQ-018 SHALL write store bytes at the accept edge, only to the addressed lanes: B writes 1 lane, H writes lanes {a+1,a}, W writes all 4 (little-endian); an erroring store writes nothing.
REQ-019 SHALL extend loads as follows: B/H sign-extended from bit 7/15; BU/HU zero-extended; W unmodified.
REQ-020 SHALL produce exactly one response per accepted request (loads and stores), in acceptance order, with rsp_valid asserted RD_LAT cycles after the accept edge absent stalls.
REQ-021 SHALL let a load accepted on any edge after a store's accept edge observe that store's data (no stale read).
REQ-022 SHALL stall the internal pipeline of RD_LAT stages (valid bit per stage) whenever rsp_valid && !rsp_ready; all stages, including bank output registers, SHALL hold.
REQ-023 SHALL drive req_ready = !(rsp_valid && !rsp_ready), combinationally; no loss or duplication under stall.
REQ-024 SHALL keep rsp_rdata/rsp_err stable while rsp_valid && !rsp_ready.
REQ-025 SHALL sustain one request per cycle when rsp_ready is held high.
REQ-026 SHALL drive rsp_rdata=0 and rsp_err=1 on an erroring response, regardless of other fields.

Reset
REQ-027 SHALL, when rst_n=0 at an edge, clear all stage valids, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 in the following cycle.
REQ-028 SHALL discard in-flight requests on reset mid-operation without producing responses; stores already accepted stay written.
REQ-029 SHALL leave memory contents unreset.

Structure
REQ-030 SHALL take funct3 codes (LS_B, LS_H, LS_W, LS_BU, LS_HU) as an enum from shared package mem_pkg.
REQ-031 SHALL instantiate sub-module byte_bank (one per lane: byte array, write enable, registered read with hold enable), so that each bank infers as BRAM.

Verification
REQ-032 SHALL cover: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, err=0, RD_LAT cycles after accept.
REQ-033 SHALL cover: SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80 and LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-034 SHALL cover: LH @0x11, SW @0x22 and LW @DEPTH_BYTES -> rsp_err=1, rdata=0 for each; memory at 0x20 unchanged.
REQ-035 SHALL cover: back-to-back loads 0x0,0x4,0x8 with rsp_ready low for 3 cycles mid-stream -> req_ready low during stall, responses in order, none dropped or duplicated.
REQ-036 SHALL cover: rst_n low for one cycle while 2 loads are in flight (RD_LAT=2) -> no responses, rsp_valid=0 next cycle, earlier stores retained.
REQ-037 SHALL run all scenarios for RD_LAT=1 and 2, with DEPTH_BYTES=4096 and 256.
